// File: rtl/shuffler3_transpose.sv
// shuffler3_transpose: 3-lane 3x3 block transpose for the radix-3 FFT datapath.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module shuffler3_transpose #(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] a2,
  output logic         out_valid,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic         sof_out
);

  // History ring: ages 1..4D are read back, age 0 is the live input.
  localparam int N  = 4 * D + 1;
  localparam int AW = $clog2(N);
  localparam int PW = $clog2(2 * D + 1);
  localparam int KW = (D > 1) ? $clog2(D) : 1;

  logic [3*W-1:0] mem [N];
  logic [3*W-1:0] cur;
  logic [AW-1:0]  wp;
  logic [PW-1:0]  prime_cnt;
  logic           primed;
  logic [KW-1:0]  k;
  logic [1:0]     b;

  assign cur    = {a2, a1, a0};
  assign primed = (prime_cnt == PW'(2 * D));

  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[wp] <= cur;
    end
  end

  // Output lane j at block b needs lane b from (b + 2 - j) blocks ago.
  for (genvar j = 0; j < 3; j++) begin : g_lane
    localparam int SH = 2 - j;
    logic [31:0]    age;
    logic [AW:0]    sum;
    logic [AW-1:0]  ra;
    logic [3*W-1:0] word;
    logic [W-1:0]   sel;

    always_comb begin
      age = (32'(b) + 32'(SH)) * 32'(D);
      sum = {1'b0, wp} + (AW+1)'(N) - (AW+1)'(age);
      if (sum >= (AW+1)'(N)) begin
        ra = AW'(sum - (AW+1)'(N));
      end else begin
        ra = sum[AW-1:0];
      end
      word = (age == 32'd0) ? cur : mem[ra];
      case (b)
        2'd0:    sel = word[W-1:0];
        2'd1:    sel = word[2*W-1:W];
        default: sel = word[3*W-1:2*W];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      prime_cnt <= '0;
      k         <= '0;
      b         <= '0;
      out_valid <= 1'b0;
      sof_out   <= 1'b0;
      y0        <= '0;
      y1        <= '0;
      y2        <= '0;
    end else if (in_valid) begin
      wp        <= (wp == AW'(N - 1)) ? '0 : wp + 1'b1;
      out_valid <= primed;
      sof_out   <= primed && (b == 2'd0) && (k == '0);
      if (!primed) begin
        prime_cnt <= prime_cnt + 1'b1;
      end else begin
        y0 <= g_lane[0].sel;
        y1 <= g_lane[1].sel;
        y2 <= g_lane[2].sel;
        if (k == KW'(D - 1)) begin
          k <= '0;
          b <= (b == 2'd2) ? 2'd0 : b + 2'd1;
        end else begin
          k <= k + 1'b1;
        end
      end
    end else begin
      out_valid <= 1'b0;
      sof_out   <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shuffler3_transpose.sv
// tb_shuffler3_transpose: table vectors for D=2 plus random stimulus against a
// frame-arithmetic reference model on three instances (D=1, 2, 4).
`default_nettype none
`timescale 1ns/1ps

module tb_shuffler3_transpose;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a0 = '0, a1 = '0, a2 = '0;
  logic         ov [3];
  logic         sf [3];
  logic [W-1:0] yy0 [3], yy1 [3], yy2 [3];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int DI = (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    shuffler3_transpose #(.W(W), .D(DI)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a0(a0), .a1(a1), .a2(a2),
      .out_valid(ov[i]), .y0(yy0[i]), .y1(yy1[i]), .y2(yy2[i]),
      .sof_out(sf[i])
    );
  end

  typedef struct {
    logic         v;
    logic [W-1:0] x0, x1, x2;
    logic         ev, es;
    logic [W-1:0] e0, e1, e2;
  } vec_t;

  vec_t         tbl [10];
  logic [W-1:0] hist [3][0:4095];
  int           nacc;
  int           n_checks = 0;
  int           n_fail = 0;
  int           exp_sof4 = 0;
  int           act_sof4 = 0;

  function automatic int dof(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  // Output beat m = n - 2D; frame f, beat t, block b, offset k; y_j = a_b[f*F + j*D + k].
  function automatic logic [W-1:0] ref_y(input int d, input int n, input int j);
    int m  = n - 2 * d;
    int fl = 3 * d;
    int f  = m / fl;
    int t  = m % fl;
    return hist[t / d][f * fl + j * d + (t % d)];
  endfunction

  task automatic chk(input string nm, input int inst, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (D=%0d): got %h expected %h", nm, dof(inst), act, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] x0, input logic [W-1:0] x1,
                       input logic [W-1:0] x2);
    logic         ev [3];
    logic         es [3];
    logic [W-1:0] e0 [3], e1 [3], e2 [3];
    in_valid = v; a0 = x0; a1 = x1; a2 = x2;
    for (int i = 0; i < 3; i++) begin
      ev[i] = 1'b0; es[i] = 1'b0; e0[i] = '0; e1[i] = '0; e2[i] = '0;
    end
    if (v) begin
      hist[0][nacc] = x0; hist[1][nacc] = x1; hist[2][nacc] = x2;
      for (int i = 0; i < 3; i++) begin
        int d = dof(i);
        if (nacc >= 2 * d) begin
          ev[i] = 1'b1;
          es[i] = ((nacc - 2 * d) % (3 * d)) == 0;
          e0[i] = ref_y(d, nacc, 0);
          e1[i] = ref_y(d, nacc, 1);
          e2[i] = ref_y(d, nacc, 2);
        end
      end
      nacc++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("out_valid", i, W'(ov[i]), W'(ev[i]));
      chk("sof_out", i, W'(sf[i]), W'(es[i]));
      if (ev[i]) begin
        chk("y0", i, yy0[i], e0[i]);
        chk("y1", i, yy1[i], e1[i]);
        chk("y2", i, yy2[i], e2[i]);
      end
    end
    if (sf[2]) act_sof4++;
    if (es[2]) exp_sof4++;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset out_valid", i, W'(ov[i]), '0);
      chk("reset sof_out", i, W'(sf[i]), '0);
      chk("reset y0", i, yy0[i], '0);
      chk("reset y1", i, yy1[i], '0);
      chk("reset y2", i, yy2[i], '0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    nacc = 0;
  endtask

  task automatic set_exp(input int r, input logic [W-1:0] e0, input logic [W-1:0] e1,
                         input logic [W-1:0] e2);
    tbl[r].ev = 1'b1; tbl[r].es = (r == 4);
    tbl[r].e0 = e0; tbl[r].e1 = e1; tbl[r].e2 = e2;
  endtask

  task automatic run_table(input bit gaps);
    logic [W-1:0] held;
    for (int r = 0; r < 10; r++) begin
      if (gaps && (r == 3 || r == 7)) begin
        held = yy0[1];
        repeat (3) begin
          cycle(1'b0, $urandom, $urandom, $urandom);
          chk("stall hold y0", 1, yy0[1], held);
        end
      end
      cycle(tbl[r].v, tbl[r].x0, tbl[r].x1, tbl[r].x2);
      chk("tbl out_valid", 1, W'(ov[1]), W'(tbl[r].ev));
      chk("tbl sof_out", 1, W'(sf[1]), W'(tbl[r].es));
      if (tbl[r].ev) begin
        chk("tbl y0", 1, yy0[1], tbl[r].e0);
        chk("tbl y1", 1, yy1[1], tbl[r].e1);
        chk("tbl y2", 1, yy2[1], tbl[r].e2);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // D=2 basic transpose: a_j[n] = 0x(j)(n); outputs from accept #4 onward.
    for (int r = 0; r < 10; r++) begin
      tbl[r].v  = 1'b1;
      tbl[r].x0 = W'(r);
      tbl[r].x1 = W'(16 + r);
      tbl[r].x2 = W'(32 + r);
      tbl[r].ev = 1'b0; tbl[r].es = 1'b0;
      tbl[r].e0 = '0; tbl[r].e1 = '0; tbl[r].e2 = '0;
    end
    set_exp(4, 32'h00, 32'h02, 32'h04);
    set_exp(5, 32'h01, 32'h03, 32'h05);
    set_exp(6, 32'h10, 32'h12, 32'h14);
    set_exp(7, 32'h11, 32'h13, 32'h15);
    set_exp(8, 32'h20, 32'h22, 32'h24);
    set_exp(9, 32'h21, 32'h23, 32'h25);

    nacc = 0;
    @(posedge clk);
    #1;
    do_reset();
    run_table(1'b0);

    do_reset();
    run_table(1'b1);

    // Random gaps and data, with an asynchronous reset mid-stream.
    do_reset();
    for (int c = 0; c < 260; c++) begin
      if (c == 130) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom);
    end
    // Flush with a continuous tail so the final frames of every instance emerge.
    for (int c = 0; c < 24; c++) begin
      cycle(1'b1, $urandom, $urandom, $urandom);
    end
    chk("sof count", 2, W'(act_sof4), W'(exp_sof4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
